dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 47 ++++
 rtl/dmem_responder_if.sv | 12 +
 rtl/dmem_ram.sv | 34 +++
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
//   mem_in_type     : request from the core data port (valid, fence, spec, instr, addr, wdata, wstrb)
//   mem_out_type    : response to the core (ready, rdata, error)
//   dmem_state_type : responder FSM states
//   dmem_reg_type   : registered copy of an accepted request
// Optional feature macro used by the design: DMEM_FAULT_EN (address-window fault reporting).
package dmem_responder_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_spec;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
        logic        mem_error;
    } mem_out_type;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_type;

    typedef struct packed {
        logic [31:0] req_addr;
        logic [31:0] req_wdata;
        logic [3:0]  req_wstrb;
        logic        req_fence;
        logic        req_fault;
    } dmem_reg_type;

    localparam int unsigned  DMEM_LATENCY_DEFAULT = 1;
    localparam dmem_reg_type init_dmem_reg        = '0;

    // True when addr falls inside [base, base + 4 * 2^depth_log2).
    function automatic logic addr_in_window(input logic [31:0] addr, input logic [31:0] base,
                                            input int unsigned depth_log2);
        logic [31:0] off;
        off = addr - base;
        if (depth_log2 + 2 >= 32) return 1'b1;
        return (off >> (depth_log2 + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-port bundle between the core (master) and the data-memory responder (slave).
//   dmem_in  : request, driven by the master
//   dmem_out : response, driven by the slave
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    mem_in_type  dmem_in;
    mem_out_type dmem_out;

    modport master (output dmem_in, input dmem_out);
    modport slave  (input dmem_in, output dmem_out);
endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM with four byte lanes, synchronous read-first port.
//   clock   : rising-edge clock
//   i_en    : access enable (read always, write on strobed lanes)
//   i_wstrb : per-byte write strobes
//   i_addr  : word index
//   i_wdata : write data
//   o_rdata : word read in the previous enabled cycle (pre-write contents)
module dmem_ram #(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                  clock,
    input  logic                  i_en,
    input  logic [3:0]            i_wstrb,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);
    logic [31:0] r_mem [0:(1 << DEPTH_LOG2) - 1];
    logic [31:0] r_rdata;

    // No reset: contents survive a responder reset.
    always_ff @(posedge clock) begin
        if (i_en) begin
            r_rdata <= r_mem[i_addr];
            for (int b = 0; b < 4; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target of the core's data port. Accepts loads, stores and fences and
// answers each with a one-cycle mem_ready pulse LATENCY cycles after the request.
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   dmem  : slave side of dmem_responder_if (dmem_in request, dmem_out response)
// Macro DMEM_FAULT_EN: when defined, requests outside [BASE, BASE + 4 * 2^DEPTH_LOG2) skip the
// RAM and respond with mem_error=1; when undefined the address wraps modulo the RAM size.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = DMEM_LATENCY_DEFAULT,
    parameter logic [31:0] BASE       = 32'h0
) (
    input logic             clock,
    input logic             reset,
    dmem_responder_if.slave dmem
);
    dmem_state_type        r_state, w_state_d;
    logic [2:0]            r_cnt, w_cnt_d;
    dmem_reg_type          r_req, w_req_d;
    logic                  w_accept;
    logic                  w_req_fault;
    logic                  w_ram_en;
    logic [3:0]            w_ram_wstrb;
    logic [DEPTH_LOG2-1:0] w_ram_addr;
    logic [31:0]           w_ram_wdata;
    logic [31:0]           w_ram_rdata;
    logic                  w_unused;

    function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [31:0] addr);
        logic [31:0] off;
`ifdef DMEM_FAULT_EN
        off = addr - BASE;
`else
        off = addr;
`endif
        return off[DEPTH_LOG2+1:2];
    endfunction

    // BUSY ignores mem_valid entirely; RESP may accept the next request back-to-back.
    assign w_accept = dmem.dmem_in.mem_valid && (r_state != BUSY);

`ifdef DMEM_FAULT_EN
    assign w_req_fault = !dmem.dmem_in.mem_fence
                         && !addr_in_window(dmem.dmem_in.mem_addr, BASE, DEPTH_LOG2);
`else
    assign w_req_fault = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_req_d   = r_req;
        unique case (r_state)
            IDLE, RESP: begin
                w_state_d = IDLE;
                if (w_accept) begin
                    w_req_d = '{req_addr:  dmem.dmem_in.mem_addr,
                                req_wdata: dmem.dmem_in.mem_wdata,
                                req_wstrb: dmem.dmem_in.mem_wstrb,
                                req_fence: dmem.dmem_in.mem_fence,
                                req_fault: w_req_fault};
                    if (LATENCY > 1) begin
                        w_state_d = BUSY;
                        w_cnt_d   = 3'(LATENCY - 1);
                    end else begin
                        w_state_d = RESP;
                    end
                end
            end
            BUSY: begin
                // The cycle with cnt=1 is the RAM access; cnt reaches 0 on entry to RESP.
                w_cnt_d = r_cnt - 3'd1;
                if (r_cnt == 3'd1) w_state_d = RESP;
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_req   <= init_dmem_reg;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_req   <= w_req_d;
        end
    end

    // Single-cycle latency must access in the request cycle, so it bypasses the request register.
    always_comb begin
        if (LATENCY == 1) begin
            w_ram_en    = w_accept && !dmem.dmem_in.mem_fence && !w_req_fault;
            w_ram_wstrb = dmem.dmem_in.mem_wstrb;
            w_ram_addr  = word_index(dmem.dmem_in.mem_addr);
            w_ram_wdata = dmem.dmem_in.mem_wdata;
        end else begin
            w_ram_en    = (r_state == BUSY) && (r_cnt == 3'd1) && !r_req.req_fence
                          && !r_req.req_fault;
            w_ram_wstrb = r_req.req_wstrb;
            w_ram_addr  = word_index(r_req.req_addr);
            w_ram_wdata = r_req.req_wdata;
        end
    end

    dmem_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clock  (clock),
        .i_en   (w_ram_en),
        .i_wstrb(w_ram_wstrb),
        .i_addr (w_ram_addr),
        .i_wdata(w_ram_wdata),
        .o_rdata(w_ram_rdata)
    );

    always_comb begin
        dmem.dmem_out = '0;
        if (r_state == RESP) begin
            dmem.dmem_out.mem_ready = 1'b1;
            dmem.dmem_out.mem_error = r_req.req_fault;
            if (!r_req.req_fence && !r_req.req_fault) dmem.dmem_out.mem_rdata = w_ram_rdata;
        end
    end

    assign w_unused = ^{dmem.dmem_in.mem_spec, dmem.dmem_in.mem_instr, dmem.dmem_in.mem_addr,
                        r_req, BASE};
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 4, 3) against a transaction-level model
// that predicts each response from request time, latency and a word-array memory image.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int NDUT  = 3;
    localparam int WORDS = 4096;

`ifdef DMEM_FAULT_EN
    localparam logic [31:0] EXP_OOB_ERR = 32'd1;
    localparam logic [31:0] EXP_WORD0   = 32'h11111111;
`else
    localparam logic [31:0] EXP_OOB_ERR = 32'd0;
    localparam logic [31:0] EXP_WORD0   = 32'h22222222;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [NDUT];
    mem_in_type  din  [NDUT];
    mem_out_type dout [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 4 : 3);
        dmem_responder_if bus ();
        assign bus.dmem_in = din[g];
        assign dout[g]     = bus.dmem_out;
        dmem_responder #(
            .DEPTH_LOG2(12),
            .LATENCY   (LAT),
            .BASE      (32'h0)
        ) u_dut (
            .clock(clk),
            .reset(rst[g]),
            .dmem (bus)
        );
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    logic [31:0] m_mem   [NDUT][WORDS];
    bit          m_known [NDUT][WORDS];
    bit          p_vld   [NDUT];
    int          p_acc   [NDUT];
    int          p_due   [NDUT];
    mem_in_type  p_req   [NDUT];
    bit          p_fault [NDUT];
    logic [31:0] p_rd    [NDUT];
    bit          p_rd_ok [NDUT];
    int          next_ok [NDUT];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 3);
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr >> 2) % WORDS);
    endfunction

    function automatic bit fault_of(input mem_in_type r);
        bit f;
        f = !r.mem_fence && (r.mem_addr >= 32'h4000);
`ifndef DMEM_FAULT_EN
        f = 1'b0;
`endif
        return f;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin : b_dut
            logic        e_rdy;
            logic        e_err;
            logic [31:0] e_rd;
            bit          rd_chk;
            int          w;
            e_rdy  = 1'b0;
            e_err  = 1'b0;
            e_rd   = 32'd0;
            rd_chk = 1'b1;
            if (rst[i]) begin
                p_vld[i]   = 1'b0;
                next_ok[i] = cyc + 1;
            end else if (p_vld[i] && p_due[i] == cyc) begin
                e_rdy = 1'b1;
                e_err = p_fault[i];
                if (!p_req[i].mem_fence && !p_fault[i]) begin
                    e_rd   = p_rd[i];
                    rd_chk = p_rd_ok[i];
                end
            end
            check($sformatf("dut%0d ready", i), 32'(dout[i].mem_ready), 32'(e_rdy));
            check($sformatf("dut%0d error", i), 32'(dout[i].mem_error), 32'(e_err));
            if (rd_chk) check($sformatf("dut%0d rdata", i), dout[i].mem_rdata, e_rd);

            if (!rst[i]) begin
                if (din[i].mem_valid && cyc >= next_ok[i]) begin
                    p_vld[i]   = 1'b1;
                    p_req[i]   = din[i];
                    p_fault[i] = fault_of(din[i]);
                    p_acc[i]   = cyc + lat_of(i) - 1;
                    p_due[i]   = cyc + lat_of(i);
                    next_ok[i] = cyc + lat_of(i);
                end
                if (p_vld[i] && p_acc[i] == cyc && !p_req[i].mem_fence && !p_fault[i]) begin
                    w          = word_of(p_req[i].mem_addr);
                    p_rd[i]    = m_mem[i][w];
                    p_rd_ok[i] = m_known[i][w];
                    for (int b = 0; b < 4; b++) begin
                        if (p_req[i].mem_wstrb[b])
                            m_mem[i][w][b*8 +: 8] = p_req[i].mem_wdata[b*8 +: 8];
                    end
                    if (p_req[i].mem_wstrb == 4'hF) m_known[i][w] = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic drive(input int i, input logic fence, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] st);
        din[i].mem_valid = 1'b1;
        din[i].mem_fence = fence;
        din[i].mem_spec  = 1'b0;
        din[i].mem_instr = 1'b0;
        din[i].mem_addr  = a;
        din[i].mem_wdata = wd;
        din[i].mem_wstrb = st;
    endtask

    // One-cycle request; returns one cycle later (the response cycle when LATENCY=1).
    task automatic issue(input int i, input logic fence, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] st);
        drive(i, fence, a, wd, st);
        step();
        din[i] = '0;
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            rst[i] = 1'b1;
            din[i] = '0;
        end
        steps(3);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("reset ready dut%0d", i), 32'(dout[i].mem_ready), 32'd0);
            rst[i] = 1'b0;
        end
        step();

        // LATENCY=1: back-to-back store then load
        drive(0, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
        step();
        drive(0, 1'b0, 32'h10, 32'h0, 4'h0);
        check("l1 store ready", 32'(dout[0].mem_ready), 32'd1);
        step();
        din[0] = '0;
        check("l1 load ready", 32'(dout[0].mem_ready), 32'd1);
        check("l1 load rdata", dout[0].mem_rdata, 32'hDEADBEEF);
        step();
        check("l1 idle ready", 32'(dout[0].mem_ready), 32'd0);
        check("l1 idle rdata", dout[0].mem_rdata, 32'd0);

        // byte strobe
        issue(0, 1'b0, 32'h10, 32'h000000AA, 4'h1);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        check("l1 strobe rdata", dout[0].mem_rdata, 32'hDEADBEAA);

        // fence: no data, RAM unchanged
        issue(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
        check("l1 fence ready", 32'(dout[0].mem_ready), 32'd1);
        check("l1 fence rdata", dout[0].mem_rdata, 32'd0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        check("l1 after fence", dout[0].mem_rdata, 32'hDEADBEAA);

        // out-of-window store (fault or alias depending on build)
        issue(0, 1'b0, 32'h0, 32'h11111111, 4'hF);
        issue(0, 1'b0, 32'h4000, 32'h22222222, 4'hF);
        check("l1 oob error", 32'(dout[0].mem_error), EXP_OOB_ERR);
        issue(0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("l1 word0", dout[0].mem_rdata, EXP_WORD0);
        step();

        // LATENCY=4: load with an ignored pulse in cycle 2
        issue(1, 1'b0, 32'h20, 32'hCAFEF00D, 4'hF);
        steps(4);
        drive(1, 1'b0, 32'h20, 32'h0, 4'h0);
        step();
        din[1] = '0;
        check("l4 c1 ready", 32'(dout[1].mem_ready), 32'd0);
        step();
        drive(1, 1'b0, 32'h20, 32'h0, 4'hF);
        check("l4 c2 ready", 32'(dout[1].mem_ready), 32'd0);
        step();
        din[1] = '0;
        check("l4 c3 ready", 32'(dout[1].mem_ready), 32'd0);
        step();
        check("l4 c4 ready", 32'(dout[1].mem_ready), 32'd1);
        check("l4 c4 rdata", dout[1].mem_rdata, 32'hCAFEF00D);
        for (int k = 5; k <= 8; k++) begin
            step();
            check($sformatf("l4 c%0d ready", k), 32'(dout[1].mem_ready), 32'd0);
        end
        issue(1, 1'b0, 32'h20, 32'h0, 4'h0);
        steps(3);
        check("l4 reload rdata", dout[1].mem_rdata, 32'hCAFEF00D);
        issue(1, 1'b1, 32'h20, 32'h0, 4'h0);
        steps(3);
        check("l4 fence ready", 32'(dout[1].mem_ready), 32'd1);
        check("l4 fence rdata", dout[1].mem_rdata, 32'd0);
        step();

        // LATENCY=3: reset mid-operation drops the pending store
        issue(2, 1'b0, 32'h30, 32'h12345678, 4'hF);
        steps(2);
        check("l3 store ready", 32'(dout[2].mem_ready), 32'd1);
        step();
        issue(2, 1'b0, 32'h30, 32'hFFFFFFFF, 4'hF);
        rst[2] = 1'b1;
        check("l3 rst c1 ready", 32'(dout[2].mem_ready), 32'd0);
        step();
        rst[2] = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            check($sformatf("l3 rst c%0d ready", k), 32'(dout[2].mem_ready), 32'd0);
            step();
        end
        issue(2, 1'b0, 32'h30, 32'h0, 4'h0);
        step();
        check("l3 post-rst early", 32'(dout[2].mem_ready), 32'd0);
        step();
        check("l3 post-rst ready", 32'(dout[2].mem_ready), 32'd1);
        check("l3 post-rst rdata", dout[2].mem_rdata, 32'h12345678);

        steps(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
